sd_dat_receive: RTL and testbench



---
 rtl/sd_dat_receive.sv | 161 ++++++++++++++++
 tb/tb_sd_dat_receive.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dat_receive.sv
// SD DAT-line single-block receiver.
// - Samples 1 or 4 DAT lanes on the sd_sample strobe.
// - Deserialises BLOCK_BYTES bytes, MSB first.
// - Checks one CRC16 per active lane and the end bit.
// - Flags a timeout when no start bit arrives in time.
module sd_dat_receive #(
  parameter int BLOCK_BYTES     = 512,
  parameter int TIMEOUT_SAMPLES = 65535
) (
  input  logic       ex_clk,
  input  logic       reset,
  input  logic       sd_sample,
  input  logic       start,
  input  logic       wide_bus,
  input  logic [3:0] dat_in,
  output logic       busy,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  output logic       done,
  output logic       crc_err,
  output logic       timeout_err
);

  localparam int BCW = $clog2(BLOCK_BYTES + 1);
  localparam int WCW = $clog2(TIMEOUT_SAMPLES + 1);

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, END} state_t;

  state_t          state, state_nx;
  logic            wide;
  logic [3:0]      lane_mask;
  logic [WCW-1:0]  wait_cnt;
  logic [BCW-1:0]  byte_cnt;
  logic [2:0]      bit_cnt;
  logic [3:0]      crc_cnt;
  logic            err_flag;
  logic [7:0]      shift_q;
  logic [7:0]      shift_nx;
  logic [15:0]     lane_crc [4];
  logic [3:0]      crc_msbs;
  logic            start_bit;
  logic            wait_last;
  logic            byte_last_sample;
  logic            byte_cnt_last;
  logic            crc_mismatch;
  logic            end_low;

  // CRC16 (x^16+x^12+x^5+1), one bit, MSB first.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign lane_mask        = wide ? 4'hF : 4'h1;
  assign start_bit        = ((dat_in & lane_mask) == 4'h0);
  assign wait_last        = (wait_cnt == WCW'(TIMEOUT_SAMPLES - 1));
  assign byte_last_sample = wide ? (bit_cnt == 3'd1) : (bit_cnt == 3'd7);
  assign byte_cnt_last    = (byte_cnt == BCW'(BLOCK_BYTES - 1));
  assign crc_msbs         = {lane_crc[3][15], lane_crc[2][15], lane_crc[1][15], lane_crc[0][15]};
  assign crc_mismatch     = |((dat_in ^ crc_msbs) & lane_mask);
  assign end_low          = ((dat_in & lane_mask) != lane_mask);
  // lane 3 carries the MSB of each nibble in 4-bit mode
  assign shift_nx         = wide ? {shift_q[3:0], dat_in} : {shift_q[6:0], dat_in[0]};

  // State register
  always_ff @(posedge ex_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state decode; only strobed cycles advance the receive phases
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (start) state_nx = WAIT_START;
      WAIT_START: if (sd_sample) begin
                    if (start_bit)      state_nx = DATA;
                    else if (wait_last) state_nx = IDLE;
                  end
      DATA:       if (sd_sample && byte_last_sample && byte_cnt_last) state_nx = CRC;
      CRC:        if (sd_sample && crc_cnt == 4'd15) state_nx = END;
      END:        if (sd_sample) state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // Control counters, error flags and registered outputs
  always_ff @(posedge ex_clk) begin
    if (reset) begin
      busy        <= 1'b0;
      byte_out    <= 8'h00;
      byte_valid  <= 1'b0;
      done        <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      wide        <= 1'b0;
      wait_cnt    <= '0;
      byte_cnt    <= '0;
      bit_cnt     <= '0;
      crc_cnt     <= '0;
      err_flag    <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          wide        <= wide_bus;
          crc_err     <= 1'b0;
          timeout_err <= 1'b0;
          busy        <= 1'b1;
          wait_cnt    <= '0;
          byte_cnt    <= '0;
          bit_cnt     <= '0;
          crc_cnt     <= '0;
          err_flag    <= 1'b0;
        end
        WAIT_START: if (sd_sample && !start_bit) begin
          if (wait_last) begin
            timeout_err <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        DATA: if (sd_sample) begin
          if (byte_last_sample) begin
            byte_out   <= shift_nx;
            byte_valid <= 1'b1;
            bit_cnt    <= '0;
            byte_cnt   <= byte_cnt + BCW'(1);
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        CRC: if (sd_sample) begin
          if (crc_mismatch) err_flag <= 1'b1;
          crc_cnt <= crc_cnt + 4'd1;
        end
        END: if (sd_sample) begin
          crc_err <= err_flag | end_low;
          done    <= 1'b1;
          busy    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Shift register and per-lane CRCs; cleared on start, so no reset needed
  always_ff @(posedge ex_clk) begin
    if (state == IDLE && start) begin
      for (int k = 0; k < 4; k++) lane_crc[k] <= 16'h0000;
    end else if (sd_sample && state == DATA) begin
      shift_q <= shift_nx;
      for (int k = 0; k < 4; k++) lane_crc[k] <= crc16_step(lane_crc[k], dat_in[k]);
    end else if (sd_sample && state == CRC) begin
      for (int k = 0; k < 4; k++) lane_crc[k] <= {lane_crc[k][14:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_sd_dat_receive.sv
// Scoreboard bench for sd_dat_receive: a 512-byte instance (A) and a
// 4-byte instance (B) share the DAT pins; only one is started at a time.
module tb_sd_dat_receive;

  logic       ex_clk = 1'b0;
  logic       reset, sd_sample, wide_bus, start_a, start_b;
  logic [3:0] dat_in;
  logic       busy_a, byte_valid_a, done_a, crc_err_a, timeout_err_a;
  logic       busy_b, byte_valid_b, done_b, crc_err_b, timeout_err_b;
  logic [7:0] byte_out_a, byte_out_b;

  always #5 ex_clk = ~ex_clk;

  sd_dat_receive #(.BLOCK_BYTES(512), .TIMEOUT_SAMPLES(8)) dut_a (
    .ex_clk(ex_clk), .reset(reset), .sd_sample(sd_sample), .start(start_a),
    .wide_bus(wide_bus), .dat_in(dat_in), .busy(busy_a), .byte_out(byte_out_a),
    .byte_valid(byte_valid_a), .done(done_a), .crc_err(crc_err_a),
    .timeout_err(timeout_err_a));

  sd_dat_receive #(.BLOCK_BYTES(4), .TIMEOUT_SAMPLES(8)) dut_b (
    .ex_clk(ex_clk), .reset(reset), .sd_sample(sd_sample), .start(start_b),
    .wide_bus(wide_bus), .dat_in(dat_in), .busy(busy_b), .byte_out(byte_out_b),
    .byte_valid(byte_valid_b), .done(done_b), .crc_err(crc_err_b),
    .timeout_err(timeout_err_b));

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         gap      = 1;
  bit         mid_start = 0;
  bit         spacing_en = 0;
  int         prev_b   = -1;
  logic [7:0] payload [$];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic [7:0] pop_a, pop_b;
  int         done_cnt [2] = '{0, 0};
  logic       last_crc [2];
  logic       last_to [2];
  logic       last_busy [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    model_crc = {c[14:0], 1'b0};
    if (fb) model_crc = model_crc ^ 16'h1021;
  endfunction

  always @(posedge ex_clk) cyc++;

  // Output monitor: pops the scoreboard on every byte and records done pulses
  always @(negedge ex_clk) begin
    if (byte_valid_a) begin
      if (exp_a.size() == 0) check("a_extra_byte", exp_a.size(), 1);
      else begin
        pop_a = exp_a.pop_front();
        check("a_byte", byte_out_a, pop_a);
      end
    end
    if (byte_valid_b) begin
      if (exp_b.size() == 0) check("b_extra_byte", exp_b.size(), 1);
      else begin
        pop_b = exp_b.pop_front();
        check("b_byte", byte_out_b, pop_b);
      end
      if (spacing_en && prev_b >= 0) check("b_byte_spacing", cyc - prev_b, 2);
      prev_b = cyc;
    end
    if (done_a) begin
      done_cnt[0]++; last_crc[0] = crc_err_a; last_to[0] = timeout_err_a; last_busy[0] = busy_a;
    end
    if (done_b) begin
      done_cnt[1]++; last_crc[1] = crc_err_b; last_to[1] = timeout_err_b; last_busy[1] = busy_b;
    end
  end

  task automatic drive_sample(input logic [3:0] d);
    dat_in = d;
    sd_sample = 1'b1;
    @(negedge ex_clk);
    sd_sample = 1'b0;
    repeat (gap) @(negedge ex_clk);
  endtask

  task automatic pulse_start(input int sel, input bit w);
    wide_bus = w;
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge ex_clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wide_bus = ~w;
  endtask

  function automatic logic [3:0] narrow(input logic b);
    logic [2:0] r;
    r = 3'($urandom_range(7));
    narrow = {r, b};
  endfunction

  task automatic send_block(input int sel, input bit wide, input int nbytes, input int abort_after,
                            input bit fixed_en, input logic [15:0] fixed_crc, input int flip_lane,
                            input int flip_bit, input logic end_val, input int n_pre,
                            input logic [3:0] pre_val);
    logic [15:0] lc [4];
    logic [7:0]  b;
    int          nsend;
    nsend = (abort_after > 0) ? abort_after : nbytes;
    for (int k = 0; k < 4; k++) lc[k] = 16'h0000;
    for (int i = 0; i < nbytes; i++) begin
      b = payload[i];
      if (wide) for (int k = 0; k < 4; k++) lc[k] = model_crc(model_crc(lc[k], b[4+k]), b[k]);
      else for (int j = 7; j >= 0; j--) lc[0] = model_crc(lc[0], b[j]);
    end
    if (fixed_en) lc[0] = fixed_crc;
    if (flip_lane >= 0) lc[flip_lane] = lc[flip_lane] ^ (16'h0001 << flip_bit);
    for (int i = 0; i < nsend; i++) begin
      if (sel == 0) exp_a.push_back(payload[i]); else exp_b.push_back(payload[i]);
    end
    prev_b = -1;
    pulse_start(sel, wide);
    for (int i = 0; i < n_pre; i++) drive_sample(wide ? pre_val : narrow(1'b1));
    drive_sample(wide ? 4'h0 : narrow(1'b0));
    for (int i = 0; i < nsend; i++) begin
      if (mid_start && i == 3) pulse_start(sel, ~wide);
      b = payload[i];
      if (wide) begin
        drive_sample(b[7:4]);
        drive_sample(b[3:0]);
      end else begin
        for (int j = 7; j >= 0; j--) drive_sample(narrow(b[j]));
      end
    end
    if (abort_after == 0) begin
      for (int j = 15; j >= 0; j--)
        drive_sample(wide ? {lc[3][j], lc[2][j], lc[1][j], lc[0][j]} : narrow(lc[0][j]));
      drive_sample(wide ? {4{end_val}} : narrow(end_val));
    end
  endtask

  task automatic wait_done(input int sel, input int prev, input logic exp_crc, input logic exp_to,
                           input string tag);
    int n;
    n = 0;
    while (done_cnt[sel] == prev && n < 50) begin
      @(negedge ex_clk);
      n++;
    end
    check({tag, "_done_count"}, done_cnt[sel], prev + 1);
    check({tag, "_crc_err"}, last_crc[sel], exp_crc);
    check({tag, "_timeout_err"}, last_to[sel], exp_to);
    check({tag, "_busy_at_done"}, last_busy[sel], 1'b0);
    check({tag, "_bytes_left"}, (sel == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  task automatic fill_payload(input int n);
    payload = {};
    for (int i = 0; i < n; i++) payload.push_back(8'($urandom_range(255)));
  endtask

  int prev;

  initial begin
    reset = 1'b1; sd_sample = 1'b0; wide_bus = 1'b0; start_a = 1'b0; start_b = 1'b0;
    dat_in = 4'hF;
    repeat (3) @(negedge ex_clk);
    reset = 1'b0;
    check("a_reset_outputs", {busy_a, byte_out_a, byte_valid_a, done_a, crc_err_a, timeout_err_a}, 0);
    check("b_reset_outputs", {busy_b, byte_out_b, byte_valid_b, done_b, crc_err_b, timeout_err_b}, 0);

    // Idle: DAT activity must not start anything
    for (int i = 0; i < 6; i++) drive_sample(4'($urandom_range(15)) & 4'hE);
    check("idle_busy", {busy_a, busy_b}, 0);

    // A: 1-bit, 512 x 0xFF, CRC 0x7FA1
    gap = 1;
    payload = {};
    for (int i = 0; i < 512; i++) payload.push_back(8'hFF);
    prev = done_cnt[0];
    send_block(0, 1'b0, 512, 0, 1'b1, 16'h7FA1, -1, 0, 1'b1, 3, 4'hF);
    wait_done(0, prev, 1'b0, 1'b0, "a_ff_block");

    // A: timeout after 8 high samples
    prev = done_cnt[0];
    pulse_start(0, 1'b0);
    for (int i = 0; i < 7; i++) drive_sample(4'hF);
    check("a_no_early_timeout", done_cnt[0], prev);
    drive_sample(4'hF);
    wait_done(0, prev, 1'b0, 1'b1, "a_timeout");
    pulse_start(0, 1'b0);
    check("a_start_clears_timeout", timeout_err_a, 1'b0);
    check("a_busy_after_start", busy_a, 1'b1);
    prev = done_cnt[0];
    for (int i = 0; i < 8; i++) drive_sample(4'hF);
    wait_done(0, prev, 1'b0, 1'b1, "a_timeout2");

    // A: reset after the 100th byte, start coincident with reset
    fill_payload(512);
    mid_start = 1;
    prev = done_cnt[0];
    send_block(0, 1'b0, 512, 100, 1'b0, 16'h0, -1, 0, 1'b1, 2, 4'hF);
    reset = 1'b1; start_a = 1'b1;
    @(negedge ex_clk);
    reset = 1'b0; start_a = 1'b0;
    check("a_reset_busy", busy_a, 1'b0);
    check("a_reset_byte_out", byte_out_a, 8'h00);
    check("a_reset_bytes_seen", exp_a.size(), 0);
    for (int i = 0; i < 20; i++) drive_sample(4'h0);
    check("a_reset_no_done", done_cnt[0], prev);
    check("a_reset_still_idle", busy_a, 1'b0);

    // A: full random block afterwards, with an ignored start during DATA
    fill_payload(512);
    prev = done_cnt[0];
    send_block(0, 1'b0, 512, 0, 1'b0, 16'h0, -1, 0, 1'b1, 1, 4'hF);
    wait_done(0, prev, 1'b0, 1'b0, "a_after_reset");
    mid_start = 0;

    // B: 4-bit, back-to-back strobes, 12 34 56 78
    gap = 0;
    spacing_en = 1;
    payload = '{8'h12, 8'h34, 8'h56, 8'h78};
    prev = done_cnt[1];
    send_block(1, 1'b1, 4, 0, 1'b0, 16'h0, -1, 0, 1'b1, 2, 4'hF);
    wait_done(1, prev, 1'b0, 1'b0, "b_wide_ok");

    // B: lane 2 CRC bit 5 flipped
    prev = done_cnt[1];
    send_block(1, 1'b1, 4, 0, 1'b0, 16'h0, 2, 5, 1'b1, 2, 4'hF);
    wait_done(1, prev, 1'b1, 1'b0, "b_lane2_crc_bad");
    spacing_en = 0;

    // B: 1-bit, correct CRC, end bit low
    gap = 1;
    fill_payload(4);
    prev = done_cnt[1];
    send_block(1, 1'b0, 4, 0, 1'b0, 16'h0, -1, 0, 1'b0, 2, 4'hF);
    wait_done(1, prev, 1'b1, 1'b0, "b_end_low");

    // B: partial low (lane 3 high) must not be taken as a start bit
    fill_payload(4);
    prev = done_cnt[1];
    send_block(1, 1'b1, 4, 0, 1'b0, 16'h0, -1, 0, 1'b1, 3, 4'h8);
    wait_done(1, prev, 1'b0, 1'b0, "b_false_start");

    // B: 1-bit with back-to-back strobes
    gap = 0;
    fill_payload(4);
    prev = done_cnt[1];
    send_block(1, 1'b0, 4, 0, 1'b0, 16'h0, -1, 0, 1'b1, 0, 4'hF);
    wait_done(1, prev, 1'b0, 1'b0, "b_narrow_fast");

    repeat (4) @(negedge ex_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
